// File: rtl/operand_reg_bank_pkg.sv
// Shared types and constants for the operand register bank.
package operand_reg_bank_pkg;

  localparam int DEPTH = 4;
  localparam int SEL_W = 2;
  localparam logic [7:0] RST_DATA = 8'h00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/operand_reg_bank_if.sv
// Write and select request channels of the operand register bank.
interface operand_reg_bank_if
  import operand_reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             wr_valid;
  logic             wr_ready;
  logic [SEL_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [SEL_W-1:0] rd_addr;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready
  );

endinterface

// File: rtl/operand_reg_bank_clear_ctrl.sv
// Clear sequencer: walks the bank one entry per cycle and pulses done on the last.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | bank open for writes/selects; clr_req starts a clear
//   ST_CLEAR | zeroing entry[ptr] each cycle; leaves after ptr==DEPTH-1
module operand_reg_bank_clear_ctrl
  import operand_reg_bank_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_req,
  output logic             clr_start,
  output logic             clr_stb,
  output logic [SEL_W-1:0] clr_ptr,
  output logic             clr_done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  // Next state, pointer and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_start = 1'b0;
    clr_stb   = 1'b0;
    clr_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          ptr_d     = '0;
          clr_start = 1'b1;
        end
      end
      ST_CLEAR: begin
        // clr_req is deliberately not looked at here: a clear cannot be restarted.
        clr_stb = 1'b1;
        ptr_d   = ptr_q + SEL_W'(1);
        if (ptr_q == SEL_W'(DEPTH - 1)) begin
          clr_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign clr_ptr = ptr_q;
  assign busy    = (state_q == ST_CLEAR);

endmodule

// File: rtl/operand_reg_bank.sv
// Four-entry operand bank feeding the 4:1 byte mux (data inputs and select).
// Optional build macro: OPERAND_REG_BANK_BYPASS_EN forwards an accepted write
// to its mux input in the same cycle; by default the inK outputs are pure flops.
module operand_reg_bank
  import operand_reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
)(
  input  logic                clk,
  input  logic                rst_n,
  operand_reg_bank_if.slave   bus,
  input  logic                clr_req,
  output logic                clr_done,
  output logic [WIDTH-1:0]    in0,
  output logic [WIDTH-1:0]    in1,
  output logic [WIDTH-1:0]    in2,
  output logic [WIDTH-1:0]    in3,
  output logic [SEL_W-1:0]    sel,
  output logic                sel_valid
);

  logic             clr_start;
  logic             clr_stb;
  logic [SEL_W-1:0] clr_ptr;
  logic             clr_busy;
  logic             accept_ok;
  logic             wr_fire;
  logic             rd_fire;

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [WIDTH-1:0] in_view [DEPTH];
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_valid_q, sel_valid_d;

  operand_reg_bank_clear_ctrl u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .clr_start (clr_start),
    .clr_stb   (clr_stb),
    .clr_ptr   (clr_ptr),
    .clr_done  (clr_done),
    .busy      (clr_busy)
  );

  // Requests are refused while clearing or while a clear is being requested.
  always_comb begin
    accept_ok = !clr_busy && !clr_req;
    wr_fire   = bus.wr_valid && accept_ok;
    rd_fire   = bus.rd_valid && accept_ok;
  end

  assign bus.wr_ready = accept_ok;
  assign bus.rd_ready = accept_ok;

  // Entry next-values: clear strobe and write never coincide since writes are refused in CLEAR.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) entry_d[k] = entry_q[k];
    if (clr_stb) entry_d[clr_ptr] = WIDTH'(RST_DATA);
    if (wr_fire) entry_d[bus.wr_addr] = bus.wr_data;
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) entry_q[k] <= WIDTH'(RST_DATA);
    end else begin
      for (int k = 0; k < DEPTH; k++) entry_q[k] <= entry_d[k];
    end
  end

  // Select next-value: entering CLEAR invalidates the select until a new request lands.
  always_comb begin
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    if (clr_start) begin
      sel_d       = '0;
      sel_valid_d = 1'b0;
    end else if (rd_fire) begin
      sel_d       = bus.rd_addr;
      sel_valid_d = 1'b1;
    end
  end

  // Select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
    end
  end

  // Mux data inputs, optionally with same-cycle forwarding of an accepted write.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) in_view[k] = entry_q[k];
`ifdef OPERAND_REG_BANK_BYPASS_EN
    if (wr_fire) in_view[bus.wr_addr] = bus.wr_data;
`else
`endif
  end

  assign in0       = in_view[0];
  assign in1       = in_view[1];
  assign in2       = in_view[2];
  assign in3       = in_view[3];
  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;

endmodule

// File: tb/tb_operand_reg_bank.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle model.
module tb_operand_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_req;
  logic       clr_done;
  logic [7:0] in0, in1, in2, in3;
  logic [1:0] sel;
  logic       sel_valid;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: bank contents, select, and which clear cycle we are in (0 = idle).
  logic [7:0] m_mem [4];
  logic [1:0] m_sel;
  logic       m_sel_v;
  int         m_phase;

  always #5 clk = ~clk;

  operand_reg_bank_if #(.WIDTH(8)) bus ();

  operand_reg_bank #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clr_req   (clr_req),
    .clr_done  (clr_done),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .sel       (sel),
    .sel_valid (sel_valid)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_mem[k] = 8'h00;
    m_sel   = 2'd0;
    m_sel_v = 1'b0;
    m_phase = 0;
  endtask

  task automatic drive(input logic wv, input logic [1:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [1:0] ra, input logic cr);
    bus.wr_valid = wv;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_valid = rv;
    bus.rd_addr  = ra;
    clr_req      = cr;
  endtask

  function automatic logic [7:0] exp_in(input int k);
    logic [7:0] v;
    v = m_mem[k];
`ifdef OPERAND_REG_BANK_BYPASS_EN
    if (m_phase == 0 && !clr_req && bus.wr_valid && int'(bus.wr_addr) == k) v = bus.wr_data;
`endif
    return v;
  endfunction

  task automatic check_outputs();
    logic rdy;
    rdy = (m_phase == 0) && !clr_req;
    check_val("wr_ready", bus.wr_ready, rdy);
    check_val("rd_ready", bus.rd_ready, rdy);
    check_val("clr_done", clr_done, m_phase == 4);
    check_val("sel", sel, m_sel);
    check_val("sel_valid", sel_valid, m_sel_v);
    check_val("in0", in0, exp_in(0));
    check_val("in1", in1, exp_in(1));
    check_val("in2", in2, exp_in(2));
    check_val("in3", in3, exp_in(3));
  endtask

  task automatic model_update();
    if (m_phase == 0) begin
      if (clr_req) begin
        m_phase = 1;
        m_sel   = 2'd0;
        m_sel_v = 1'b0;
      end else begin
        if (bus.wr_valid) m_mem[bus.wr_addr] = bus.wr_data;
        if (bus.rd_valid) begin
          m_sel   = bus.rd_addr;
          m_sel_v = 1'b1;
        end
      end
    end else begin
      m_mem[m_phase - 1] = 8'h00;
      m_phase = (m_phase == 4) ? 0 : m_phase + 1;
    end
  endtask

  // One clock: check mid-cycle, advance the model on the edge, then leave room to drive.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write to entry 2.
    drive(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    step();
    check_val("in2_after_write", in2, 8'hA5);

    // Select entry 3, then hold with rd_valid low.
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    repeat (3) step();

    // Write entry 0 and observe the same-cycle / next-cycle behaviour.
    drive(1'b1, 2'd0, 8'h5A, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    step();

    // Load all entries, then clear; clr_req during CLEAR must be ignored.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'(8'h11 * (k + 1)), 1'b0, 2'd0, 1'b0);
      step();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    repeat (4) step();
    check_val("clear_all_zero", {in0, in1, in2, in3}, 32'h0);

    // Clear wins over a simultaneous write to entry 1.
    drive(1'b1, 2'd1, 8'hFF, 1'b1, 2'd2, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    repeat (5) step();
    check_val("in1_write_refused", in1, 8'h00);

    // Random traffic, occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0));
      step();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    repeat (5) step();

    // Make the bank non-zero, then reset in the 2nd CLEAR cycle.
    drive(1'b1, 2'd3, 8'hC3, 1'b1, 2'd1, 1'b0);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    step();
    check_val("in_clear_phase", m_phase, 2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
